// File: rtl/sync_fifo_pkg.sv
// Read-mode encodings shared by the FIFO variants of this unit.
package sync_fifo_pkg;

  localparam bit FWFT_MODE = 1'b1;
  localparam bit REG_MODE  = 1'b0;

endpackage

// File: rtl/sync_fifomem.sv
// FIFO storage: register array, one synchronous write port, asynchronous read port.
module sync_fifomem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, level, registered occupancy flags, sticky error flags,
// and either first-word-fall-through or registered read data.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH          = 16,
  parameter int ADDR_WIDTH          = 4,
  parameter bit FWFT                = FWFT_MODE,
  parameter int ALMOST_FULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int PTR_WIDTH = ADDR_WIDTH + 1;

  if (ADDR_WIDTH < 1 ||
      ALMOST_FULL_THRESH < 0 || ALMOST_FULL_THRESH > DEPTH ||
      ALMOST_EMPTY_THRESH < 0 || ALMOST_EMPTY_THRESH > DEPTH) begin : g_param_check
    $error("sync_fifo: illegal ADDR_WIDTH or threshold parameter");
  end

  logic [PTR_WIDTH-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  afull_q, afull_d, aempty_q, aempty_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, mem_rdata;
  logic                  push_acc, pop_acc, clear;

  // Flags are registered, so acceptance never depends combinationally on the other side.
  assign push_acc = push_i & ~full_q;
  assign pop_acc  = pop_i & ~empty_q;
  assign clear    = reset_i | clr_i;

  always_comb begin
    wptr_d   = wptr_q + PTR_WIDTH'(push_acc);
    rptr_d   = rptr_q + PTR_WIDTH'(pop_acc);
    level_d  = level_q + PTR_WIDTH'(push_acc) - PTR_WIDTH'(pop_acc);
    empty_d  = (wptr_d == rptr_d);
    full_d   = (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]) &&
               (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]);
    afull_d  = (level_d >= PTR_WIDTH'(ALMOST_FULL_THRESH));
    aempty_d = (level_d <= PTR_WIDTH'(ALMOST_EMPTY_THRESH));
    ovf_d    = ovf_q | (push_i & full_q);
    udf_d    = udf_q | (pop_i & empty_q);
    rvalid_d = pop_acc;
    rdata_d  = pop_acc ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= (ALMOST_FULL_THRESH == 0);
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  sync_fifomem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_i  (clk_i),
    .wr_en_i(push_acc & ~clear),
    .waddr_i(wptr_q[ADDR_WIDTH-1:0]),
    .wdata_i(wdata_i),
    .raddr_i(rptr_q[ADDR_WIDTH-1:0]),
    .rdata_o(mem_rdata)
  );

  assign rdata_o        = (FWFT == FWFT_MODE) ? mem_rdata : rdata_q;
  assign rvalid_o       = (FWFT == FWFT_MODE) ? ~empty_q : rvalid_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign level_o        = level_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: one FWFT instance and one registered-read instance on shared stimulus.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0, clr = 1'b0, push = 1'b0, pop = 1'b0;
  logic [15:0] wdata = '0;

  logic        f_full, f_afull, f_rvalid, f_empty, f_aempty, f_ovf, f_udf;
  logic [15:0] f_rdata;
  logic [4:0]  f_level;
  logic        r_full, r_afull, r_rvalid, r_empty, r_aempty, r_ovf, r_udf;
  logic [15:0] r_rdata;
  logic [4:0]  r_level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_fifo #(.FWFT(FWFT_MODE)) u_dut_fwft (
    .clk_i(clk), .reset_i(reset), .clr_i(clr), .push_i(push), .wdata_i(wdata),
    .full_o(f_full), .almost_full_o(f_afull), .pop_i(pop), .rdata_o(f_rdata),
    .rvalid_o(f_rvalid), .empty_o(f_empty), .almost_empty_o(f_aempty),
    .level_o(f_level), .overflow_o(f_ovf), .underflow_o(f_udf)
  );

  sync_fifo #(.FWFT(REG_MODE)) u_dut_reg (
    .clk_i(clk), .reset_i(reset), .clr_i(clr), .push_i(push), .wdata_i(wdata),
    .full_o(r_full), .almost_full_o(r_afull), .pop_i(pop), .rdata_o(r_rdata),
    .rvalid_o(r_rvalid), .empty_o(r_empty), .almost_empty_o(r_aempty),
    .level_o(r_level), .overflow_o(r_ovf), .underflow_o(r_udf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_test(input bit use_reset);
    for (int i = 0; i < 17; i++) begin
      push = 1'b1; wdata = 16'(16'h0200 + i);
      step();
    end
    push = 1'b0; pop = 1'b1;
    for (int i = 0; i < 11; i++) step();
    pop = 1'b0;
    check("flush_pre_level", 32'(f_level), 32'd5);
    check("flush_pre_ovf", 32'(f_ovf), 32'd1);
    if (use_reset) reset = 1'b1; else clr = 1'b1;
    push = 1'b1; wdata = 16'hDEAD;
    step();
    reset = 1'b0; clr = 1'b0; push = 1'b0;
    check("flush_level", 32'(f_level), 32'd0);
    check("flush_empty", 32'(f_empty), 32'd1);
    check("flush_full", 32'(f_full), 32'd0);
    check("flush_aempty", 32'(f_aempty), 32'd1);
    check("flush_ovf", 32'(f_ovf), 32'd0);
    check("flush_rvalid", 32'(r_rvalid), 32'd0);
    step();
    check("flush_push_ignored", 32'(f_level), 32'd0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_level", 32'(f_level), 32'd0);
    check("rst_empty", 32'(f_empty), 32'd1);
    check("rst_full", 32'(f_full), 32'd0);
    check("rst_aempty", 32'(f_aempty), 32'd1);
    check("rst_afull", 32'(f_afull), 32'd0);
    check("rst_ovf", 32'(f_ovf), 32'd0);
    check("rst_udf", 32'(f_udf), 32'd0);
    check("rst_rvalid_fwft", 32'(f_rvalid), 32'd0);
    check("rst_rvalid_reg", 32'(r_rvalid), 32'd0);
    check("rst_rdata_reg", 32'(r_rdata), 32'd0);

    // Fill 0x0001..0x0010
    for (int i = 1; i <= 16; i++) begin
      push = 1'b1; wdata = 16'(i);
      step();
      check("fill_level", 32'(f_level), 32'(i));
      check("fill_afull", 32'(f_afull), 32'(i >= 14));
      check("fill_full", 32'(f_full), 32'(i == 16));
      check("fill_aempty", 32'(f_aempty), 32'(i <= 2));
      check("fill_head", 32'(f_rdata), 32'h1);
    end

    // Push+pop while full: pop accepted, push rejected
    push = 1'b1; pop = 1'b1; wdata = 16'hBEEF;
    step();
    push = 1'b0; pop = 1'b0;
    check("ovf_level", 32'(f_level), 32'd15);
    check("ovf_flag", 32'(f_ovf), 32'd1);
    check("ovf_full", 32'(f_full), 32'd0);

    // Drain the remaining 15; 0xBEEF must never appear
    for (int i = 2; i <= 16; i++) begin
      check("drain_data", 32'(f_rdata), 32'(i));
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    check("drain_empty", 32'(f_empty), 32'd1);
    check("drain_level", 32'(f_level), 32'd0);
    check("drain_udf", 32'(f_udf), 32'd0);
    check("drain_rvalid", 32'(f_rvalid), 32'd0);

    // Push+pop while empty: push accepted, pop rejected
    push = 1'b1; pop = 1'b1; wdata = 16'h00AA;
    step();
    push = 1'b0; pop = 1'b0;
    check("udf_flag", 32'(f_udf), 32'd1);
    check("udf_level", 32'(f_level), 32'd1);
    check("udf_data", 32'(f_rdata), 32'h00AA);
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("udf_drain", 32'(f_empty), 32'd1);

    // Steady push+pop at level 3 across several pointer wraps
    for (int k = 0; k < 3; k++) begin
      push = 1'b1; wdata = 16'(16'h0100 + k);
      step();
    end
    for (int k = 0; k < 40; k++) begin
      check("wrap_data", 32'(f_rdata), 32'(16'h0100 + k));
      push = 1'b1; pop = 1'b1; wdata = 16'(16'h0103 + k);
      step();
      check("wrap_level", 32'(f_level), 32'd3);
      check("wrap_full", 32'(f_full), 32'd0);
      check("wrap_empty", 32'(f_empty), 32'd0);
    end
    push = 1'b0;
    for (int k = 40; k < 43; k++) begin
      check("wrap_tail", 32'(f_rdata), 32'(16'h0100 + k));
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    check("wrap_end_empty", 32'(f_empty), 32'd1);
    check("sticky_ovf", 32'(f_ovf), 32'd1);
    check("sticky_udf", 32'(f_udf), 32'd1);

    // Registered-read mode
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("reg_clr_rdata", 32'(r_rdata), 32'd0);
    push = 1'b1; wdata = 16'h1234;
    step();
    push = 1'b0;
    check("reg_pre_rvalid", 32'(r_rvalid), 32'd0);
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("reg_rvalid_n1", 32'(r_rvalid), 32'd1);
    check("reg_rdata_n1", 32'(r_rdata), 32'h1234);
    step();
    check("reg_rvalid_n2", 32'(r_rvalid), 32'd0);
    check("reg_rdata_hold", 32'(r_rdata), 32'h1234);
    check("reg_empty", 32'(r_empty), 32'd1);

    // Flush with clr_i, then with reset_i
    flush_test(1'b0);
    flush_test(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
